// File: rtl/iir_biquad_engine.sv
// iir_biquad_engine: cascade of direct-form-I biquads time-multiplexed onto one MAC.
// The coefficient bank is loadable; each section keeps its delay line internally.
module iir_biquad_engine #(
  parameter int N = 24,
  parameter int F = 15,
  parameter int SECTIONS = 2
)(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [N-1:0]                    x_in,
  input  logic                            coef_we,
  input  logic [$clog2(5*SECTIONS)-1:0]   coef_addr,
  input  logic [N-1:0]                    coef_data,
  input  logic                            clr,
  output logic                            busy,
  output logic                            done,
  output logic [N-1:0]                    y_out,
  output logic                            ovf
);
  localparam int AW = $clog2(5*SECTIONS);
  localparam int SW = SECTIONS > 1 ? $clog2(SECTIONS) : 1;
  localparam int A = 2*N-F+3;
  localparam logic signed [A-1:0] MAXV = {{(A-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [A-1:0] MINV = {{(A-N+1){1'b1}}, {(N-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, UPD, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [2:0] tap_q, tap_d;
  logic signed [A-1:0] acc_q, acc_d;
  logic signed [N-1:0] xs_q, xs_d;
  logic [N-1:0] y_q, y_d;
  logic ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic signed [N-1:0] coef_q [5*SECTIONS];
  logic signed [N-1:0] coef_d [5*SECTIONS];
  logic signed [N-1:0] x1_q [SECTIONS];
  logic signed [N-1:0] x1_d [SECTIONS];
  logic signed [N-1:0] x2_q [SECTIONS];
  logic signed [N-1:0] x2_d [SECTIONS];
  logic signed [N-1:0] y1_q [SECTIONS];
  logic signed [N-1:0] y1_d [SECTIONS];
  logic signed [N-1:0] y2_q [SECTIONS];
  logic signed [N-1:0] y2_d [SECTIONS];
  logic [AW-1:0] cidx;
  logic signed [N-1:0] c_op, d_op;
  logic signed [2*N-1:0] prod;
  logic signed [A-1:0] term;
  logic hi, lo;
  logic [N-1:0] sat;
  // Operand mux: tap selects (b0,x) (b1,x1) (b2,x2) (a1,y1) (a2,y2) of the current section
  assign cidx = AW'(5*int'(sec_q) + int'(tap_q));
  assign c_op = coef_q[cidx];
  assign d_op = tap_q == 3'd0 ? xs_q :
                tap_q == 3'd1 ? x1_q[sec_q] :
                tap_q == 3'd2 ? x2_q[sec_q] :
                tap_q == 3'd3 ? y1_q[sec_q] : y2_q[sec_q];
  assign prod = c_op * d_op;
  assign term = A'(prod >>> F);
  assign hi = acc_q > MAXV;
  assign lo = acc_q < MINV;
  assign sat = hi ? {1'b0, {(N-1){1'b1}}} : lo ? {1'b1, {(N-1){1'b0}}} : acc_q[N-1:0];
  always_comb begin
    state_d = state_q;
    sec_d = sec_q;
    tap_d = tap_q;
    acc_d = acc_q;
    xs_d = xs_q;
    y_d = y_q;
    ovf_d = ovf_q;
    coef_d = coef_q;
    x1_d = x1_q;
    x2_d = x2_q;
    y1_d = y1_q;
    y2_d = y2_q;
    if (state_q == IDLE) begin
      if (clr) begin
        for (int i = 0; i < SECTIONS; i++) begin
          x1_d[i] = '0;
          x2_d[i] = '0;
          y1_d[i] = '0;
          y2_d[i] = '0;
        end
        ovf_d = 1'b0;
      end
      if (coef_we && int'(coef_addr) < 5*SECTIONS) coef_d[coef_addr] = coef_data;
      if (start) begin
        xs_d = x_in;
        sec_d = '0;
        tap_d = '0;
        acc_d = '0;
        state_d = MAC;
      end
    end else if (state_q == MAC) begin
      acc_d = acc_q + term;
      tap_d = tap_q + 3'd1;
      if (tap_q == 3'd4) state_d = UPD;
    end else if (state_q == UPD) begin
      x2_d[sec_q] = x1_q[sec_q];
      x1_d[sec_q] = xs_q;
      y2_d[sec_q] = y1_q[sec_q];
      y1_d[sec_q] = sat;
      xs_d = sat;
      ovf_d = ovf_q | hi | lo;
      if (int'(sec_q) == SECTIONS-1) begin
        y_d = sat;
        state_d = DONE;
      end else begin
        sec_d = sec_q + 1'b1;
        tap_d = '0;
        acc_d = '0;
        state_d = MAC;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sec_q <= '0;
      tap_q <= '0;
      acc_q <= '0;
      xs_q <= '0;
      y_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 5*SECTIONS; i++) coef_q[i] <= (i % 5 == 0) ? N'(1 << F) : '0;
      for (int i = 0; i < SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      tap_q <= tap_d;
      acc_q <= acc_d;
      xs_q <= xs_d;
      y_q <= y_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      coef_q <= coef_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign y_out = y_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_iir_biquad_engine.sv
// tb_iir_biquad_engine: directed vector table plus hand-written sequences for
// busy-time, clr and mid-operation reset behaviour of the two-section engine.
module tb_iir_biquad_engine;
  logic clk = 1'b0;
  logic reset_n, start, coef_we, clr;
  logic [23:0] x_in, coef_data;
  logic [3:0] coef_addr;
  logic busy, done, ovf;
  logic [23:0] y_out;
  int total = 0;
  int passed = 0;
  int lat;
  typedef struct {
    bit rst;
    bit cw;
    logic [3:0] ca;
    logic [23:0] cd;
    bit go;
    logic [23:0] x;
    logic [23:0] ey;
    bit eo;
  } vec_t;
  vec_t vt[$];

  iir_biquad_engine #(.N(24), .F(15), .SECTIONS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .clr(clr),
    .busy(busy), .done(done), .y_out(y_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Issues one sample and waits (bounded) for done; lat counts negedges since start
  task automatic sample(input logic [23:0] xv, input bit cl, output int l);
    start = 1'b1;
    x_in = xv;
    clr = cl;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    int dn;
    reset_n = 1'b0;
    start = 1'b0;
    coef_we = 1'b0;
    clr = 1'b0;
    x_in = '0;
    coef_data = '0;
    coef_addr = '0;
    @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y_out, 0);
    chk("rst_ovf", ovf, 0);

    vt.push_back('{1, 0, 4'd0,  24'h000000, 1, 24'h004000, 24'h004000, 0});
    vt.push_back('{0, 1, 4'd15, 24'h000000, 1, 24'h004000, 24'h004000, 0});
    vt.push_back('{1, 0, 4'd0,  24'h000000, 1, 24'hFFC000, 24'hFFC000, 0});
    vt.push_back('{1, 1, 4'd0,  24'h002000, 0, 24'h000000, 24'h000000, 0});
    vt.push_back('{0, 1, 4'd1,  24'h002000, 0, 24'h000000, 24'h000000, 0});
    vt.push_back('{0, 1, 4'd2,  24'h002000, 0, 24'h000000, 24'h000000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h008000, 24'h002000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h002000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h002000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h000000, 0});
    vt.push_back('{1, 1, 4'd3,  24'h004000, 1, 24'h008000, 24'h008000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h004000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h002000, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000000, 24'h001000, 0});
    vt.push_back('{1, 1, 4'd5,  24'h004000, 1, 24'h008000, 24'h004000, 0});
    vt.push_back('{1, 1, 4'd0,  24'h004000, 1, 24'hFFFFFF, 24'hFFFFFF, 0});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h000001, 24'h000000, 0});
    vt.push_back('{1, 1, 4'd0,  24'h010000, 1, 24'h640000, 24'h7FFFFF, 1});
    vt.push_back('{0, 0, 4'd0,  24'h000000, 1, 24'h9C0000, 24'h800000, 1});

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      if (vt[i].cw) wr(vt[i].ca, vt[i].cd);
      if (vt[i].go) begin
        sample(vt[i].x, 1'b0, lat);
        chk($sformatf("v%0d_y", i), y_out, vt[i].ey);
        chk($sformatf("v%0d_ovf", i), ovf, vt[i].eo);
        chk($sformatf("v%0d_lat", i), lat, 14);
      end
    end

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    sample(24'h000000, 1'b0, lat);
    chk("clr_zero_y", y_out, 0);
    chk("clr_zero_ovf", ovf, 0);

    do_reset();
    wr(4'd3, 24'h004000);
    sample(24'h008000, 1'b0, lat);
    chk("clrstart_pre_y", y_out, 24'h008000);
    sample(24'h000000, 1'b1, lat);
    chk("clrstart_y", y_out, 24'h000000);

    do_reset();
    start = 1'b1;
    x_in = 24'h004000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_mid", busy, 1);
    start = 1'b1;
    x_in = 24'h001234;
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 24'h000000;
    @(negedge clk);
    start = 1'b0;
    coef_we = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("poke_lat", lat, 14);
    chk("poke_y", y_out, 24'h004000);
    chk("done_busy_low", busy, 0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("poke_not_queued", dn, 0);
    sample(24'h002000, 1'b0, lat);
    chk("poke_old_b0_y", y_out, 24'h002000);

    do_reset();
    wr(4'd0, 24'h004000);
    sample(24'h008000, 1'b0, lat);
    chk("abort_pre_y", y_out, 24'h004000);
    start = 1'b1;
    x_in = 24'h008000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 7; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_y", y_out, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    sample(24'h008000, 1'b0, lat);
    chk("abort_identity_y", y_out, 24'h008000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
